// File: rtl/param_lock_fsm.sv
// Keypad lock controller: configurable code length, confirm-before-lock, failed-attempt lockout.
// Optional feature: define LOCK_MASTER_CODE_EN to accept MASTER_CODE at unlock and during lockout.
module param_lock_fsm #(
    parameter int unsigned CLOCK_FREQ      = 50000000,
    parameter int unsigned TIMEOUT         = 10*CLOCK_FREQ,
    parameter int unsigned PASSCODE_LENGTH = 4,
    parameter int unsigned DIGIT_WIDTH     = 4,
    parameter int unsigned MAX_ATTEMPTS    = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 30*CLOCK_FREQ,
    parameter logic [PASSCODE_LENGTH*DIGIT_WIDTH-1:0] DEFAULT_PASSCODE = 'h8148,
    parameter logic [PASSCODE_LENGTH*DIGIT_WIDTH-1:0] MASTER_CODE      = 'h0000
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [DIGIT_WIDTH-1:0]                    key,
    output logic                                      locked,
    output logic                                      error,
    output logic                                      lockout,
    output logic [PASSCODE_LENGTH*DIGIT_WIDTH-1:0]    userEntry,
    output logic [$clog2(PASSCODE_LENGTH+1)-1:0]      entryLength,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]         failCount,
    output logic [2:0]                                dbg_state
);

    localparam int CODE_W = PASSCODE_LENGTH*DIGIT_WIDTH;
    localparam int LEN_W  = $clog2(PASSCODE_LENGTH+1);
    localparam int FAIL_W = $clog2(MAX_ATTEMPTS+1);
    localparam int IDLE_W = $clog2(TIMEOUT+1);
    localparam int LCK_W  = $clog2(LOCKOUT_CYCLES+1);

    typedef enum logic [2:0] {
        OPEN_READ1   = 3'd0,
        OPEN_READ2   = 3'd1,
        OPEN_CHECK   = 3'd2,
        LOCKED_READ  = 3'd3,
        LOCKED_CHECK = 3'd4,
        LOCKOUT      = 3'd5
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CODE_W-1:0]   r_saved,   w_saved_nxt;
    logic [CODE_W-1:0]   r_pending, w_pending_nxt;
    logic [CODE_W-1:0]   r_entry,   w_entry_nxt;
    logic [LEN_W-1:0]    r_len,     w_len_nxt;
    logic                r_armed,   w_armed_nxt;
    logic [IDLE_W-1:0]   r_idle,    w_idle_nxt;
    logic [LCK_W-1:0]    r_lck_cnt, w_lck_cnt_nxt;
    logic                r_locked,  w_locked_nxt;
    logic                r_error,   w_error_nxt;
    logic                r_lockout, w_lockout_nxt;
    logic [FAIL_W-1:0]   r_fail,    w_fail_nxt;

    logic                w_full;
    logic                w_press;
    logic                w_lock_done;
    logic [CODE_W-1:0]   w_entry_shift;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                w_unused_params;

    assign w_full        = (r_len == LEN_W'(PASSCODE_LENGTH));
    assign w_press       = (key != '0) && r_armed;
    assign w_lock_done   = (r_lck_cnt == LCK_W'(LOCKOUT_CYCLES-1));
    assign w_entry_shift = (r_entry << DIGIT_WIDTH) | CODE_W'(key);
    assign w_fail_inc    = r_fail + FAIL_W'(1);

`ifdef LOCK_MASTER_CODE_EN
    assign w_unused_params = ^CLOCK_FREQ;
`else
    assign w_unused_params = ^{MASTER_CODE, CLOCK_FREQ};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_saved_nxt   = r_saved;
        w_pending_nxt = r_pending;
        w_entry_nxt   = r_entry;
        w_len_nxt     = r_len;
        w_armed_nxt   = r_armed;
        w_idle_nxt    = '0;
        w_lck_cnt_nxt = r_lck_cnt;
        w_locked_nxt  = r_locked;
        w_error_nxt   = r_error;
        w_lockout_nxt = r_lockout;
        w_fail_nxt    = r_fail;

        case (r_state)
            OPEN_READ1, OPEN_READ2, LOCKED_READ: begin
                if (w_full) begin
                    // A full entry moves on; the key is ignored and armed is left alone.
                    case (r_state)
                        OPEN_READ1: begin
                            w_pending_nxt = r_entry;
                            w_entry_nxt   = '0;
                            w_len_nxt     = '0;
                            w_state_nxt   = OPEN_READ2;
                        end
                        OPEN_READ2: w_state_nxt = OPEN_CHECK;
                        default:    w_state_nxt = LOCKED_CHECK;
                    endcase
                end else if (w_press) begin
                    w_entry_nxt = w_entry_shift;
                    w_len_nxt   = r_len + LEN_W'(1);
                    w_armed_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                end else begin
                    if (key == '0) w_armed_nxt = 1'b1;
                    if (r_len != '0) begin
                        if (r_idle == IDLE_W'(TIMEOUT-1)) begin
                            w_error_nxt = 1'b1;
                            w_entry_nxt = '0;
                            w_len_nxt   = '0;
                            if (r_state == OPEN_READ2) w_state_nxt = OPEN_READ1;
                        end else begin
                            w_idle_nxt = r_idle + IDLE_W'(1);
                        end
                    end
                end
            end

            OPEN_CHECK: begin
                w_entry_nxt = '0;
                w_len_nxt   = '0;
                if (r_entry == r_pending) begin
                    w_saved_nxt  = r_entry;
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = LOCKED_READ;
                end else begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = OPEN_READ1;
                end
            end

            LOCKED_CHECK: begin
                w_entry_nxt = '0;
                w_len_nxt   = '0;
`ifdef LOCK_MASTER_CODE_EN
                if (r_entry == r_saved || r_entry == MASTER_CODE) begin
`else
                if (r_entry == r_saved) begin
`endif
                    w_locked_nxt = 1'b0;
                    w_fail_nxt   = '0;
                    w_state_nxt  = OPEN_READ1;
                end else begin
                    w_error_nxt = 1'b1;
                    w_fail_nxt  = w_fail_inc;
                    if (w_fail_inc == FAIL_W'(MAX_ATTEMPTS)) begin
                        w_lockout_nxt = 1'b1;
                        w_lck_cnt_nxt = '0;
                        w_state_nxt   = LOCKOUT;
                    end else begin
                        w_state_nxt = LOCKED_READ;
                    end
                end
            end

            LOCKOUT: begin
`ifdef LOCK_MASTER_CODE_EN
                if (w_full && r_entry == MASTER_CODE) begin
                    w_lockout_nxt = 1'b0;
                    w_locked_nxt  = 1'b0;
                    w_fail_nxt    = '0;
                    w_entry_nxt   = '0;
                    w_len_nxt     = '0;
                    w_state_nxt   = OPEN_READ1;
                end else if (w_lock_done) begin
                    w_lockout_nxt = 1'b0;
                    w_fail_nxt    = '0;
                    w_entry_nxt   = '0;
                    w_len_nxt     = '0;
                    w_state_nxt   = LOCKED_READ;
                end else begin
                    w_lck_cnt_nxt = r_lck_cnt + LCK_W'(1);
                    if (w_full) begin
                        w_entry_nxt = '0;
                        w_len_nxt   = '0;
                    end else if (w_press) begin
                        w_entry_nxt = w_entry_shift;
                        w_len_nxt   = r_len + LEN_W'(1);
                        w_armed_nxt = 1'b0;
                        w_error_nxt = 1'b0;
                    end else if (key == '0) begin
                        w_armed_nxt = 1'b1;
                    end
                end
`else
                if (key == '0) w_armed_nxt = 1'b1;
                if (w_lock_done) begin
                    w_lockout_nxt = 1'b0;
                    w_fail_nxt    = '0;
                    w_state_nxt   = LOCKED_READ;
                end else begin
                    w_lck_cnt_nxt = r_lck_cnt + LCK_W'(1);
                end
`endif
            end

            default: w_state_nxt = OPEN_READ1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= OPEN_READ1;
            r_saved   <= DEFAULT_PASSCODE;
            r_pending <= '0;
            r_entry   <= '0;
            r_len     <= '0;
            r_armed   <= 1'b0;
            r_idle    <= '0;
            r_lck_cnt <= '0;
            r_locked  <= 1'b0;
            r_error   <= 1'b0;
            r_lockout <= 1'b0;
            r_fail    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_saved   <= w_saved_nxt;
            r_pending <= w_pending_nxt;
            r_entry   <= w_entry_nxt;
            r_len     <= w_len_nxt;
            r_armed   <= w_armed_nxt;
            r_idle    <= w_idle_nxt;
            r_lck_cnt <= w_lck_cnt_nxt;
            r_locked  <= w_locked_nxt;
            r_error   <= w_error_nxt;
            r_lockout <= w_lockout_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

    assign locked      = r_locked;
    assign error       = r_error;
    assign lockout     = r_lockout;
    assign userEntry   = r_entry;
    assign entryLength = r_len;
    assign failCount   = r_fail;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_param_lock_fsm.sv
// Directed bench for param_lock_fsm: drivers push expected output snapshots, a negedge monitor compares them.
module tb_param_lock_fsm;

    localparam int CW = 16;
    localparam int LW = 3;
    localparam int FW = 2;
    localparam int XW = 3 + FW + LW + CW;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      key   = 4'd0;
    logic            locked;
    logic            error;
    logic            lockout;
    logic [CW-1:0]   userEntry;
    logic [LW-1:0]   entryLength;
    logic [FW-1:0]   failCount;
    logic [2:0]      dbg_state;

    param_lock_fsm #(
        .CLOCK_FREQ     (100),
        .TIMEOUT        (20),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key         (key),
        .locked      (locked),
        .error       (error),
        .lockout     (lockout),
        .userEntry   (userEntry),
        .entryLength (entryLength),
        .failCount   (failCount),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard
    logic [XW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [XW-1:0] pack(input logic lk, input logic er, input logic lo,
                                           input logic [FW-1:0] fc, input logic [LW-1:0] ln,
                                           input logic [CW-1:0] ue);
        return {lk, er, lo, fc, ln, ue};
    endfunction

    task automatic expect_out(input string nm, input logic lk, input logic er, input logic lo,
                              input logic [FW-1:0] fc, input logic [LW-1:0] ln, input logic [CW-1:0] ue);
        exp_q.push_back(pack(lk, er, lo, fc, ln, ue));
        name_q.push_back(nm);
    endtask

    // monitor
    always @(negedge clock) begin : monitor
        logic [XW-1:0] e;
        logic [XW-1:0] a;
        string         n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = pack(locked, error, lockout, failCount, entryLength, userEntry);
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got lk=%0b er=%0b lo=%0b fc=%0d len=%0d ue=%h, want lk=%0b er=%0b lo=%0b fc=%0d len=%0d ue=%h",
                         n, a[XW-1], a[XW-2], a[XW-3], a[CW+LW+FW-1 -: FW], a[CW+LW-1 -: LW], a[CW-1:0],
                         e[XW-1], e[XW-2], e[XW-3], e[CW+LW+FW-1 -: FW], e[CW+LW-1 -: LW], e[CW-1:0]);
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key = d;
        tick(1);
        key = 4'd0;
        tick(1);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
        key = 4'd0;
        tick(2);
    endtask

    initial begin
        // 1: held key after reset yields no digit
        key = 4'd3;
        tick(2);
        reset = 1'b1;
        tick(3);
        expect_out("held_key_ignored", 0, 0, 0, 0, 0, 16'h0000);
        key = 4'd0;
        tick(1);
        expect_out("after_release", 0, 0, 0, 0, 0, 16'h0000);

        // 2: confirm-before-lock, latency, unlock
        enter_code(16'h1234);
        expect_out("first_entry_done", 0, 0, 0, 0, 0, 16'h0000);
        press(4'd1); press(4'd2); press(4'd3);
        key = 4'd4;
        tick(1);
        expect_out("eighth_digit", 0, 0, 0, 0, 4, 16'h1234);
        key = 4'd0;
        tick(1);
        expect_out("lock_edge1", 0, 0, 0, 0, 4, 16'h1234);
        tick(1);
        expect_out("lock_edge2", 1, 0, 0, 0, 0, 16'h0000);
        tick(1);
        enter_code(16'h1234);
        expect_out("unlock_ok", 0, 0, 0, 0, 0, 16'h0000);

        // 4: failed attempts and lockout
        enter_code(16'h1234);
        enter_code(16'h1234);
        expect_out("relock", 1, 0, 0, 0, 0, 16'h0000);
        enter_code(16'h9999);
        expect_out("fail1", 1, 1, 0, 1, 0, 16'h0000);
        enter_code(16'h9999);
        expect_out("fail2", 1, 1, 0, 2, 0, 16'h0000);
        enter_code(16'h9999);
        expect_out("fail3_lockout", 1, 1, 1, 3, 0, 16'h0000);
        press(4'd5); press(4'd5); press(4'd5); press(4'd5);
        expect_out("lockout_keys_ignored", 1, 1, 1, 3, 0, 16'h0000);
        tick(40);
        expect_out("lockout_last_cycle", 1, 1, 1, 3, 0, 16'h0000);
        tick(1);
        expect_out("lockout_expired", 1, 1, 0, 0, 0, 16'h0000);
        enter_code(16'h1234);
        expect_out("unlock_after_lockout", 0, 0, 0, 0, 0, 16'h0000);

        // 3: confirmation mismatch
        enter_code(16'h1234);
        enter_code(16'h1235);
        expect_out("confirm_mismatch", 0, 1, 0, 0, 0, 16'h0000);
        press(4'd7);
        expect_out("digit_clears_error", 0, 0, 0, 0, 1, 16'h0007);

        // 5: idle timeout and the digit-wins boundary
        press(4'd8);
        tick(18);
        expect_out("idle_19", 0, 0, 0, 0, 2, 16'h0078);
        tick(1);
        expect_out("idle_timeout", 0, 1, 0, 0, 0, 16'h0000);
        press(4'd5);
        press(4'd6);
        tick(18);
        key = 4'd9;
        tick(1);
        expect_out("digit_at_timeout", 0, 0, 0, 0, 3, 16'h0569);
        key = 4'd0;
        tick(1);

        // 6: mid-entry reset, then default code
        reset = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0, 0, 0, 16'h0000);
        tick(1);
        reset = 1'b1;
        tick(1);
        enter_code(16'h8148);
        enter_code(16'h8148);
        expect_out("lock_default_code", 1, 0, 0, 0, 0, 16'h0000);
        enter_code(16'h8148);
        expect_out("unlock_default_code", 0, 0, 0, 0, 0, 16'h0000);

        tick(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
